// File: rtl/stage1_act.sv
// stage1_act: post-accumulation stage for layer 1.
// Captures N accumulator lanes in one cycle, then streams one activation per
// cycle (bias add, ReLU, arithmetic right shift by SHIFT, saturate to OUT_W
// bits) over a valid/ready handshake.
// Build option: define STAGE1_ACT_BIAS_EN to add the per-lane bias; when it is
// undefined the bias input is ignored and bias_idx is tied to 0.
module stage1_act #(
    parameter int N     = 32,
    parameter int SHIFT = 8,
    parameter int OUT_W = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load,
    input  logic [32*N-1:0]        p_flat,
    output logic                   busy,
    output logic [$clog2(N)-1:0]   bias_idx,
    input  logic [31:0]            bias,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic                   out_last
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [32:0]   SAT  = 33'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx;
    logic signed [31:0]  lane_q [N];
    logic                advance;

    logic signed [31:0]  lane_cur;
    logic signed [31:0]  bias_term;
    logic signed [32:0]  sum;
    logic [32:0]         shifted;
    logic [OUT_W-1:0]    act;

`ifdef STAGE1_ACT_BIAS_EN
    assign bias_term = bias;
`else
    logic unused_bias;
    assign unused_bias = ^bias;
    assign bias_term   = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode, busy and bias index.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        bias_idx = '0;
        advance  = !out_valid || out_ready;
        case (state_q)
            IDLE: begin
                if (load) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
`ifdef STAGE1_ACT_BIAS_EN
                bias_idx = idx;
`endif
                if (advance && idx == LAST) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_valid && out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-lane arithmetic: 33-bit sum cannot wrap; ReLU, shift, saturate.
    always_comb begin
        lane_cur = lane_q[idx];
        sum      = $signed({lane_cur[31], lane_cur}) + $signed({bias_term[31], bias_term});
        shifted  = $unsigned(sum) >> SHIFT;
        act      = '0;
        if (!sum[32] && sum != '0) begin
            if (shifted > SAT) act = '1;
            else               act = shifted[OUT_W-1:0];
        end
    end

    // Lane capture on an accepted load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < N; i++) lane_q[i] <= '0;
        end else if (state_q == IDLE && load) begin
            for (int unsigned i = 0; i < N; i++) lane_q[i] <= p_flat[32*i +: 32];
        end
    end

    // Lane counter and output register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) idx <= '0;
                end
                RUN: begin
                    if (advance) begin
                        out_data  <= act;
                        out_idx   <= idx;
                        out_last  <= (idx == LAST);
                        out_valid <= 1'b1;
                        idx       <= idx + IW'(1);
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage1_act.sv
// tb_stage1_act: directed bench for stage1_act (N=32, SHIFT=8, OUT_W=8).
// Expected activations are hand-computed per test; where the bias option
// changes the result both values are listed and selected by the macro.
module tb_stage1_act;

    localparam int N = 32;
`ifdef STAGE1_ACT_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn;
    logic              load;
    logic [32*N-1:0]   p_flat;
    logic              busy;
    logic [4:0]        bias_idx;
    logic [31:0]       bias;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [4:0]        out_idx;
    logic              out_last;

    logic [31:0]       bias_tab [N];
    logic [7:0]        exp_data [N];
    logic [7:0]        acc_data [N];
    logic [4:0]        acc_idx  [N];
    logic              acc_last [N];
    int                first_cyc, last_cyc;
    int unsigned       n_cmp = 0;
    int unsigned       n_err = 0;

    assign bias = bias_tab[bias_idx];

    stage1_act #(.N(N), .SHIFT(8), .OUT_W(8)) dut (
        .clk(clk), .resetn(resetn), .load(load), .p_flat(p_flat),
        .busy(busy), .bias_idx(bias_idx), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [31:0] v);
        p_flat[32*i +: 32] = v;
    endtask

    task automatic do_load(input string name);
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check({name, " busy_after_load"}, busy, 1);
        check({name, " valid_after_load"}, out_valid, 0);
        check({name, " bias_idx_lane0"}, bias_idx, 0);
    endtask

    // Accept transfers with the given ready duty; optional load injection at
    // lane 10 and in the final-handshake cycle; optional early exit at stop_at.
    task automatic collect(input int unsigned duty, input bit inject, input int stop_at,
                           input logic [32*N-1:0] p_alt, input string name);
        int unsigned cnt = 0;
        int unsigned nxt = 1;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [7:0]  pd = '0;
        logic [4:0]  pi = '0;
        logic        pl = 1'b0;
        first_cyc = -1;
        last_cyc  = -1;
        while (cnt < N && cyc < 4000) begin
            @(negedge clk);
            if (stop_at >= 0 && out_valid && int'(out_idx) == stop_at) return;
            if (stalled) begin
                check({name, " stall_data"}, out_data, pd);
                check({name, " stall_idx"}, out_idx, pi);
                check({name, " stall_last"}, out_last, pl);
            end
            if (nxt < N)
                check($sformatf("%s bias_idx%0d", name, nxt), bias_idx, BIAS_EN ? nxt : 0);
            load = 1'b0;
            out_ready = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
            if (inject && out_valid && out_idx == 5'd10) begin
                load   = 1'b1;
                p_flat = p_alt;
            end
            if (out_valid && out_ready) begin
                acc_data[cnt] = out_data;
                acc_idx[cnt]  = out_idx;
                acc_last[cnt] = out_last;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (inject && out_last) load = 1'b1;
                cnt++;
                if (nxt < N) nxt++;
            end
            stalled = out_valid && !out_ready;
            pd = out_data;
            pi = out_idx;
            pl = out_last;
            cyc++;
        end
        check({name, " xfer_count"}, cnt, N);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s data%0d", name, i), acc_data[i], exp_data[i]);
            check($sformatf("%s idx%0d", name, i), acc_idx[i], i);
            check($sformatf("%s last%0d", name, i), acc_last[i], (i == N - 1));
        end
    endtask

    task automatic end_frame(input string name);
        @(negedge clk);
        check({name, " busy_after_final"}, busy, 0);
        check({name, " valid_after_final"}, out_valid, 0);
        check({name, " last_after_final"}, out_last, 0);
    endtask

    task automatic basic_frame();
        for (int i = 0; i < N; i++) begin
            set_lane(i, i * 256);
            bias_tab[i] = '0;
            exp_data[i] = 8'(i);
        end
    endtask

    initial begin
        logic [32*N-1:0] p_alt;
        resetn    = 1'b0;
        load      = 1'b0;
        out_ready = 1'b1;
        p_flat    = '0;
        p_alt     = '0;
        for (int i = 0; i < N; i++) bias_tab[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst valid", out_valid, 0);
        check("rst data", out_data, 0);
        check("rst idx", out_idx, 0);
        check("rst last", out_last, 0);
        check("rst bias_idx", bias_idx, 0);
        resetn = 1'b1;

        // Basic stream, one lane per cycle
        basic_frame();
        do_load("basic");
        collect(100, 1'b0, -1, p_alt, "basic");
        check("basic first_cycle", first_cyc, 0);
        check("basic last_cycle", last_cyc, N - 1);
        end_frame("basic");

        // Bias, ReLU, saturation and no-wrap sum
        for (int i = 0; i < N; i++) begin
            set_lane(i, i * 256 + 32'h80);
            bias_tab[i] = '0;
            exp_data[i] = 8'(i);
        end
        set_lane(0, -32'sd1000);       bias_tab[0]  = 32'd500;       exp_data[0]  = 8'd0;
        set_lane(1, 32'd100);          bias_tab[1]  = -32'sd200;     exp_data[1]  = BIAS_EN ? 8'd0 : 8'd0;
        set_lane(2, 32'd0);            bias_tab[2]  = 32'd768;       exp_data[2]  = BIAS_EN ? 8'd3 : 8'd0;
        set_lane(3, 32'h7FFFFFFF);     bias_tab[3]  = 32'h7FFFFFFF;  exp_data[3]  = 8'd255;
        set_lane(4, 32'h0000FF00);     bias_tab[4]  = 32'h100;       exp_data[4]  = 8'd255;
        set_lane(5, 32'h0000FEFF);     bias_tab[5]  = 32'h0;         exp_data[5]  = 8'd254;
        set_lane(6, 32'hFFFFFFFF);     bias_tab[6]  = 32'h0;         exp_data[6]  = 8'd0;
        set_lane(7, 32'h00000200);     bias_tab[7]  = 32'hFFFFFF00;  exp_data[7]  = BIAS_EN ? 8'd1 : 8'd2;
        set_lane(8, 32'h80000000);     bias_tab[8]  = 32'h7FFFFFFF;  exp_data[8]  = 8'd0;
        set_lane(9, 32'h000000FF);     bias_tab[9]  = 32'h1;         exp_data[9]  = BIAS_EN ? 8'd1 : 8'd0;
        set_lane(10, 32'h80000000);    bias_tab[10] = 32'h80000000;  exp_data[10] = 8'd0;
        set_lane(11, 32'h000000FF);    bias_tab[11] = 32'h0;         exp_data[11] = 8'd0;
        do_load("bias");
        collect(100, 1'b0, -1, p_alt, "bias");
        end_frame("bias");

        // Constant bias 0x1000 on every lane
        basic_frame();
        for (int i = 0; i < N; i++) begin
            bias_tab[i] = 32'h1000;
            exp_data[i] = BIAS_EN ? 8'(i + 16) : 8'(i);
        end
        do_load("cbias");
        collect(100, 1'b0, -1, p_alt, "cbias");
        end_frame("cbias");

        // Backpressure at 30% ready duty
        basic_frame();
        do_load("bp");
        collect(30, 1'b0, -1, p_alt, "bp");
        end_frame("bp");
        out_ready = 1'b1;

        // Loads while busy are ignored; a load right after the final handshake is taken
        basic_frame();
        for (int i = 0; i < N; i++) p_alt[32*i +: 32] = (N - 1 - i) * 256;
        do_load("lwb");
        collect(100, 1'b1, -1, p_alt, "lwb");
        end_frame("lwb");
        @(negedge clk);
        load = 1'b0;
        check("lwb reload_busy", busy, 1);
        check("lwb reload_valid", out_valid, 0);
        for (int i = 0; i < N; i++) exp_data[i] = 8'(N - 1 - i);
        collect(100, 1'b0, -1, p_alt, "lwb2");
        end_frame("lwb2");

        // Asynchronous reset during lane 15
        basic_frame();
        do_load("rstmid");
        collect(100, 1'b0, 15, p_alt, "rstmid");
        check("rstmid valid_before", out_valid, 1);
        #1 resetn = 1'b0;
        #1;
        check("rstmid busy", busy, 0);
        check("rstmid valid", out_valid, 0);
        check("rstmid data", out_data, 0);
        check("rstmid idx", out_idx, 0);
        check("rstmid last", out_last, 0);
        check("rstmid bias_idx", bias_idx, 0);
        @(negedge clk);
        resetn = 1'b1;
        do_load("after_rst");
        collect(100, 1'b0, -1, p_alt, "after_rst");
        check("after_rst first_cycle", first_cyc, 0);
        end_frame("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
